// File: rtl/jtpopeye_pkg.sv
// Shared types for the Popeye object-buffer DMA sequencer.
// Holds the sequencer state encoding and the default strobe count per frame.
package jtpopeye_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } roh_state_t;

  localparam int ROH_XFER_LEN = 128;

endpackage

// File: rtl/jtgng_prom.sv
// Generic synchronous PROM with a runtime write port.
// Reads are registered; a read and a write to the same address return the old word.
module jtgng_prom #(
  parameter int aw      = 8,
  parameter int dw      = 4,
  parameter     simfile = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [dw-1:0] data,
  input  logic [aw-1:0] rd_addr,
  input  logic [aw-1:0] wr_addr,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] r_mem [0:(1<<aw)-1];

  // Write port: memory contents survive reset.
  always_ff @(posedge clk) begin
    if (cen && we) begin
      r_mem[wr_addr] <= data;
    end
  end

  // Read port: non-blocking write above makes same-address reads see the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {dw{1'b0}};
    end else if (cen) begin
      q <= r_mem[rd_addr];
    end
  end

endmodule

// File: rtl/jtpopeye_roh_seq.sv
// Sprite-DMA sequencer: requests the CPU bus at vertical blank, issues a fixed
// number of H-paced ROHVCK strobes, then releases the bus. Also hosts the timing PROM.
module jtpopeye_roh_seq
  import jtpopeye_pkg::*;
#(
  parameter int XFER_LEN = ROH_XFER_LEN,
  parameter int PROM_AW  = 8,
  parameter int PROM_DW  = 4,
  parameter     SIMFILE  = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               VB_n,
  input  logic               AI_n,
  input  logic               BI_n,
  input  logic               HBD_n,
  input  logic               DM10,
  input  logic               busak,
  output logic               MR_n,
  output logic               ROHVS,
  output logic               ROHVCK,
  input  logic [PROM_AW-1:0] prom_rd_addr,
  input  logic [PROM_AW-1:0] prom_wr_addr,
  input  logic               prom_we,
  input  logic [PROM_DW-1:0] prom_din,
  output logic [PROM_DW-1:0] prom_q
);

  localparam logic [8:0] LEN9 = 9'(XFER_LEN);

  roh_state_t r_state;
  roh_state_t w_state_nx;
  logic [8:0] r_cnt;
  logic [8:0] w_cnt_nx;
  logic       r_vb_prev;
  logic [1:0] r_h_prev;
  logic       r_mr_n;
  logic       r_rohvs;
  logic       r_rohvck;
  logic       w_vb_fall;
  logic       w_tick;
  logic       w_strobe;

  assign w_vb_fall = r_vb_prev & ~VB_n;
  // H[1:0] reaching 11 shows up as the inverted pair landing on 00
  assign w_tick    = (r_h_prev != 2'b00) && ({BI_n, AI_n} == 2'b00);

  // Edge-detect history: reset as if blanking is inactive and H[1:0] is 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vb_prev <= 1'b1;
      r_h_prev  <= 2'b11;
    end else begin
      r_vb_prev <= VB_n;
      r_h_prev  <= {BI_n, AI_n};
    end
  end

  // Next-state and strobe decode; leaving blanking overrides everything.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_strobe   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vb_fall && DM10) begin
          w_state_nx = ST_REQ;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (busak) begin
          w_state_nx = ST_XFER;
        end else begin
          w_state_nx = ST_REQ;
        end
      end
      ST_XFER: begin
        // completion is checked a cycle after the last strobe, so the bus is held through it
        if (r_cnt == LEN9) begin
          w_state_nx = ST_DONE;
        end else if (!busak) begin
          w_state_nx = ST_REQ;
        end else if (w_tick && !HBD_n) begin
          w_strobe = 1'b1;
          w_cnt_nx = r_cnt + 9'd1;
        end else begin
          w_state_nx = ST_XFER;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_DONE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    if (VB_n) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = 9'd0;
      w_strobe   = 1'b0;
    end else begin
      w_cnt_nx   = w_cnt_nx;
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 9'd0;
      r_mr_n   <= 1'b1;
      r_rohvs  <= 1'b0;
      r_rohvck <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_mr_n   <= !((w_state_nx == ST_REQ) || (w_state_nx == ST_XFER));
      r_rohvs  <= (w_state_nx == ST_XFER);
      r_rohvck <= w_strobe;
    end
  end

  assign MR_n   = r_mr_n;
  assign ROHVS  = r_rohvs;
  assign ROHVCK = r_rohvck;

  jtgng_prom #(
    .aw      (PROM_AW),
    .dw      (PROM_DW),
    .simfile (SIMFILE)
  ) u_prom (
    .clk     (clk),
    .rst     (rst),
    .cen     (1'b1),
    .data    (prom_din),
    .rd_addr (prom_rd_addr),
    .wr_addr (prom_wr_addr),
    .we      (prom_we),
    .q       (prom_q)
  );

endmodule

// File: tb/tb_jtpopeye_roh_seq.sv
// Self-checking bench for jtpopeye_roh_seq: a stimulus-side model predicts the
// cycle of every ROHVCK strobe into a queue that a negedge monitor drains.
module tb_jtpopeye_roh_seq;

  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       VB_n, AI_n, BI_n, HBD_n, DM10, busak;
  logic       MR_n, ROHVS, ROHVCK;
  logic [7:0] prom_rd_addr, prom_wr_addr;
  logic       prom_we;
  logic [3:0] prom_din, prom_q;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_strobes = 0;
  int exp_q[$];

  // stimulus-side model
  logic [1:0] h = 2'd0;
  bit m_vb = 1'b1, m_bak = 1'b0, armed = 1'b0;
  int remaining = LEN;

  jtpopeye_roh_seq #(.XFER_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .VB_n(VB_n), .AI_n(AI_n), .BI_n(BI_n), .HBD_n(HBD_n),
    .DM10(DM10), .busak(busak), .MR_n(MR_n), .ROHVS(ROHVS), .ROHVCK(ROHVCK),
    .prom_rd_addr(prom_rd_addr), .prom_wr_addr(prom_wr_addr), .prom_we(prom_we),
    .prom_din(prom_din), .prom_q(prom_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every strobe must land on a cycle the model predicted.
  always @(negedge clk) begin
    if (!rst && ROHVCK) begin
      n_strobes++;
      if (exp_q.size() == 0) chk("rohvck_unexpected", cyc, -1);
      else chk("rohvck_cycle", cyc, exp_q.pop_front());
    end
  end

  // One clock of stimulus; H advances every cycle.
  task automatic drive(input bit vb, input bit dm, input bit bak, input bit hbd);
    logic [1:0] hn;
    bit tick;
    hn   = h + 2'd1;
    tick = (h != 2'd3) && (hn == 2'd3);
    VB_n = vb; DM10 = dm; busak = bak; HBD_n = hbd;
    AI_n = ~hn[0]; BI_n = ~hn[1];
    if (vb) begin
      armed = 1'b0;
      remaining = LEN;
    end else if (m_vb) begin
      armed = dm;
    end else if (armed && m_bak && bak && !hbd && tick && remaining > 0) begin
      exp_q.push_back(cyc + 1);
      remaining--;
    end
    h = hn; m_vb = vb; m_bak = bak;
    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input bit vb, input bit dm, input bit bak, input bit hbd);
    repeat (n) drive(vb, dm, bak, hbd);
  endtask

  // Blanking falls, then busak rises three cycles later.
  task automatic start_frame(input bit dm);
    run(2, 1'b1, dm, 1'b0, 1'b0);
    n_strobes = 0;
    drive(1'b0, dm, 1'b0, 1'b0);
    @(negedge clk);
    chk("mr_n_after_vb_fall", MR_n, dm ? 0 : 1);
    run(2, 1'b0, dm, 1'b0, 1'b0);
    drive(1'b0, dm, 1'b1, 1'b0);
    @(negedge clk);
    chk("rohvs_after_busak", ROHVS, dm ? 1 : 0);
  endtask

  task automatic wait_remaining(input int target, input string tag);
    int guard = 0;
    while (remaining > target && guard < 40) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      guard++;
    end
    if (guard >= 40) chk(tag, remaining, target);
  endtask

  task automatic finish_frame(input string tag);
    run(30, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk({tag, "_mr_n"}, MR_n, 1);
    chk({tag, "_rohvs"}, ROHVS, 0);
    chk({tag, "_strobes"}, n_strobes, LEN);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; VB_n = 1'b1; DM10 = 1'b0; busak = 1'b0; HBD_n = 1'b1;
    AI_n = 1'b1; BI_n = 1'b1;
    prom_rd_addr = 8'h00; prom_wr_addr = 8'h00; prom_we = 1'b0; prom_din = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mr_n", MR_n, 1);
    chk("rst_rohvs", ROHVS, 0);
    chk("rst_rohvck", ROHVCK, 0);
    chk("rst_prom_q", prom_q, 0);
    rst = 1'b0;
    run(2, 1'b1, 1'b0, 1'b0, 1'b0);

    // PROM write then read, then same-cycle read/write
    prom_we = 1'b1; prom_wr_addr = 8'h3C; prom_din = 4'hA;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    prom_we = 1'b0; prom_rd_addr = 8'h3C;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("prom_read", prom_q, 4'hA);
    prom_we = 1'b1; prom_din = 4'h5;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("prom_rw_old", prom_q, 4'hA);
    prom_we = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("prom_rw_new", prom_q, 4'h5);

    // full transfer
    start_frame(1'b1);
    finish_frame("full");

    // DM10 low at the blanking edge disables the whole frame
    start_frame(1'b0);
    run(20, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("dm10_off_mr_n", MR_n, 1);
    chk("dm10_off_strobes", n_strobes, 0);

    // two ticks outside the DMA window are skipped
    start_frame(1'b1);
    wait_remaining(LEN - 1, "hbd_wait");
    run(8, 1'b0, 1'b1, 1'b1, 1'b1);
    finish_frame("hbd");

    // bus pause after two strobes
    start_frame(1'b1);
    wait_remaining(LEN - 2, "pause_wait");
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("pause_rohvs", ROHVS, 0);
    chk("pause_mr_n", MR_n, 0);
    run(6, 1'b0, 1'b1, 1'b0, 1'b0);
    finish_frame("pause");

    // abort by blanking end, then a clean frame
    start_frame(1'b1);
    wait_remaining(LEN - 1, "abort_wait");
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("abort_mr_n", MR_n, 1);
    chk("abort_rohvs", ROHVS, 0);
    chk("abort_strobes", n_strobes, 1);
    start_frame(1'b1);
    finish_frame("after_abort");

    // asynchronous reset in the middle of a transfer
    start_frame(1'b1);
    run(2, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_rohvs", ROHVS, 1);
    #1 rst = 1'b1;
    VB_n = 1'b1; busak = 1'b0;
    #1;
    chk("async_rst_mr_n", MR_n, 1);
    chk("async_rst_rohvs", ROHVS, 0);
    chk("async_rst_rohvck", ROHVCK, 0);
    exp_q.delete();
    armed = 1'b0; remaining = LEN; m_vb = 1'b1; m_bak = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_mr_n", MR_n, 1);
    chk("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
